// File: rtl/mips_cpu_pkg.sv
// Types and constants shared across the MIPS pipeline stages.
package mips_cpu_pkg;

   typedef logic [31:0] reg_t;
   typedef logic [4:0]  reg_addr_t;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_B    = 3'd1,
      LD_BU   = 3'd2,
      LD_H    = 3'd3,
      LD_HU   = 3'd4,
      LD_W    = 3'd5
   } ld_op_t;

   localparam reg_addr_t REG_NOP = 5'd0;
   localparam reg_t      ZERO    = 32'h0000_0000;

   typedef struct packed {
      logic      wreg;
      reg_addr_t wd;
      reg_t      wdata;
      ld_op_t    ld_op;
      logic [1:0] byte_off;
      reg_t      rdata;
      logic      whilo;
      reg_t      hi;
      reg_t      lo;
   } memwb_t;

   localparam memwb_t MEMWB_BUBBLE = '{
      wreg: 1'b0, wd: REG_NOP, wdata: ZERO, ld_op: LD_NONE,
      byte_off: 2'b00, rdata: ZERO, whilo: 1'b0, hi: ZERO, lo: ZERO
   };

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load-data alignment and extension for the write-back port (little-endian lanes).
module load_ext
   import mips_cpu_pkg::*;
(
   input  ld_op_t     ld_op_i,
   input  logic [1:0] byte_off_i,
   input  reg_t       rdata_i,
   input  reg_t       wdata_i,
   output reg_t       rfwd_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'h00;
      case (byte_off_i)
         2'd0: byte_v = rdata_i[7:0];
         2'd1: byte_v = rdata_i[15:8];
         2'd2: byte_v = rdata_i[23:16];
         2'd3: byte_v = rdata_i[31:24];
         default: byte_v = 8'h00;
      endcase
      // Halfword misalignment traps upstream, so only bit 1 picks the half.
      half_v = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      rfwd_o = wdata_i;
      case (ld_op_i)
         LD_B:    rfwd_o = {{24{byte_v[7]}}, byte_v};
         LD_BU:   rfwd_o = {24'h0, byte_v};
         LD_H:    rfwd_o = {{16{half_v[15]}}, half_v};
         LD_HU:   rfwd_o = {16'h0, half_v};
         LD_W:    rfwd_o = rdata_i;
         default: rfwd_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, register-file write port and architectural HI/LO.
module wb_stage
   import mips_cpu_pkg::*;
(
   input  logic       cpu_clk_50M,
   input  logic       cpu_rst,
   input  logic       stall,
   input  logic       flush,
   input  logic       mem_wreg,
   input  reg_addr_t  mem_wd,
   input  reg_t       mem_wdata,
   input  ld_op_t     mem_ld_op,
   input  logic [1:0] mem_byte_off,
   input  reg_t       mem_rdata,
   input  logic       mem_whilo,
   input  reg_t       mem_hi,
   input  reg_t       mem_lo,
   output logic       rfwe,
   output reg_addr_t  rfwa,
   output reg_t       rfwd,
   output logic       wb_whilo,
   output reg_t       wb_hi,
   output reg_t       wb_lo,
   output reg_t       hi_o,
   output reg_t       lo_o
);

   memwb_t memwb_q, memwb_d;
   reg_t   hi_q, hi_d, lo_q, lo_d;

   always_comb begin
      memwb_d = memwb_q;
      if (flush) begin
         memwb_d = MEMWB_BUBBLE;
      end else if (!stall) begin
         memwb_d.wreg     = mem_wreg;
         memwb_d.wd       = mem_wd;
         memwb_d.wdata    = mem_wdata;
         memwb_d.ld_op    = mem_ld_op;
         memwb_d.byte_off = mem_byte_off;
         memwb_d.rdata    = mem_rdata;
         memwb_d.whilo    = mem_whilo;
         memwb_d.hi       = mem_hi;
         memwb_d.lo       = mem_lo;
      end
   end

   // A held request re-commits the same values during stall, which is harmless.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (memwb_q.whilo) begin
         hi_d = memwb_q.hi;
         lo_d = memwb_q.lo;
      end
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         memwb_q <= MEMWB_BUBBLE;
         hi_q    <= ZERO;
         lo_q    <= ZERO;
      end else begin
         memwb_q <= memwb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   load_ext u_load_ext (
      .ld_op_i    (memwb_q.ld_op),
      .byte_off_i (memwb_q.byte_off),
      .rdata_i    (memwb_q.rdata),
      .wdata_i    (memwb_q.wdata),
      .rfwd_o     (rfwd)
   );

   assign rfwe     = memwb_q.wreg && (memwb_q.wd != REG_NOP);
   assign rfwa     = memwb_q.wd;
   assign wb_whilo = memwb_q.whilo;
   assign wb_hi    = memwb_q.hi;
   assign wb_lo    = memwb_q.lo;
   assign hi_o     = hi_q;
   assign lo_o     = lo_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus queues expected outputs, monitor checks them.
module tb_wb_stage;
   import mips_cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, stall, flush, wreg, whilo;
   reg_addr_t  wd;
   reg_t       wdata, rdata, hi, lo;
   ld_op_t     ldop;
   logic [1:0] off;

   logic       rfwe, wb_whilo;
   reg_addr_t  rfwa;
   reg_t       rfwd, wb_hi, wb_lo, hi_o, lo_o;

   typedef struct {
      logic      rfwe;
      reg_addr_t rfwa;
      reg_t      rfwd;
      logic      whilo;
      reg_t      whi;
      reg_t      wlo;
      reg_t      hi;
      reg_t      lo;
      string     name;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .cpu_clk_50M (clk),
      .cpu_rst     (rst),
      .stall       (stall),
      .flush       (flush),
      .mem_wreg    (wreg),
      .mem_wd      (wd),
      .mem_wdata   (wdata),
      .mem_ld_op   (ldop),
      .mem_byte_off(off),
      .mem_rdata   (rdata),
      .mem_whilo   (whilo),
      .mem_hi      (hi),
      .mem_lo      (lo),
      .rfwe        (rfwe),
      .rfwa        (rfwa),
      .rfwd        (rfwd),
      .wb_whilo    (wb_whilo),
      .wb_hi       (wb_hi),
      .wb_lo       (wb_lo),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   // Monitor: one expectation is consumed per edge that follows a queued stimulus.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (rfwe !== e.rfwe || rfwa !== e.rfwa || rfwd !== e.rfwd ||
                wb_whilo !== e.whilo || wb_hi !== e.whi || wb_lo !== e.wlo ||
                hi_o !== e.hi || lo_o !== e.lo) begin
               errors++;
               $display("FAIL %s: got we=%0b wa=%0d wd=%h whilo=%0b whi=%h wlo=%h hi=%h lo=%h; want we=%0b wa=%0d wd=%h whilo=%0b whi=%h wlo=%h hi=%h lo=%h",
                        e.name, rfwe, rfwa, rfwd, wb_whilo, wb_hi, wb_lo, hi_o, lo_o,
                        e.rfwe, e.rfwa, e.rfwd, e.whilo, e.whi, e.wlo, e.hi, e.lo);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue what must be visible after the next edge.
   task automatic cyc(input logic r, input logic s, input logic f,
                      input logic we, input reg_addr_t a, input reg_t d,
                      input ld_op_t op, input logic [1:0] bo, input reg_t rd,
                      input logic hw, input reg_t h, input reg_t l,
                      input logic x_we, input reg_addr_t x_wa, input reg_t x_wd,
                      input logic x_hw, input reg_t x_wh, input reg_t x_wl,
                      input reg_t x_hi, input reg_t x_lo, input string nm);
      exp_t e;
      rst = r; stall = s; flush = f; wreg = we; wd = a; wdata = d;
      ldop = op; off = bo; rdata = rd; whilo = hw; hi = h; lo = l;
      e.rfwe = x_we; e.rfwa = x_wa; e.rfwd = x_wd;
      e.whilo = x_hw; e.whi = x_wh; e.wlo = x_wl;
      e.hi = x_hi; e.lo = x_lo; e.name = nm;
      exp_q.push_back(e);
      @(posedge clk);
      #3;
   endtask

   localparam reg_t RD = 32'h80FF7F01;
   localparam reg_t HV = 32'hDEAD0001;
   localparam reg_t LV = 32'hBEEF0002;

   initial begin
      // Reset with a live write and HI/LO request on the inputs
      cyc(1,0,0, 1,5,32'h11, LD_NONE,0,0, 1,32'h33,32'h44,  0,0,0, 0,0,0, 0,0, "reset0");
      cyc(1,0,0, 1,5,32'h11, LD_NONE,0,0, 1,32'h33,32'h44,  0,0,0, 0,0,0, 0,0, "reset1");
      // ALU result and the r0 write suppression
      cyc(0,0,0, 1,5,32'h12345678, LD_NONE,0,0, 0,0,0,  1,5,32'h12345678, 0,0,0, 0,0, "alu");
      cyc(0,0,0, 1,0,32'h55, LD_NONE,0,0, 0,0,0,  0,0,32'h55, 0,0,0, 0,0, "r0");
      // Loads
      cyc(0,0,0, 1,8,32'hCAFE, LD_B, 3,RD, 0,0,0,  1,8,32'hFFFFFF80, 0,0,0, 0,0, "lb3");
      cyc(0,0,0, 1,8,32'hCAFE, LD_BU,3,RD, 0,0,0,  1,8,32'h00000080, 0,0,0, 0,0, "lbu3");
      cyc(0,0,0, 1,8,32'hCAFE, LD_H, 2,RD, 0,0,0,  1,8,32'hFFFF80FF, 0,0,0, 0,0, "lh2");
      cyc(0,0,0, 1,8,32'hCAFE, LD_HU,0,RD, 0,0,0,  1,8,32'h00007F01, 0,0,0, 0,0, "lhu0");
      cyc(0,0,0, 1,8,32'hCAFE, LD_W, 2,RD, 0,0,0,  1,8,32'h80FF7F01, 0,0,0, 0,0, "lw2");
      cyc(0,0,0, 1,8,32'hCAFE, LD_B, 0,RD, 0,0,0,  1,8,32'h00000001, 0,0,0, 0,0, "lb0");
      cyc(0,0,0, 1,8,32'hCAFE, LD_BU,1,RD, 0,0,0,  1,8,32'h0000007F, 0,0,0, 0,0, "lbu1");
      cyc(0,0,0, 1,8,32'hCAFE, LD_H, 3,RD, 0,0,0,  1,8,32'hFFFF80FF, 0,0,0, 0,0, "lh3");
      cyc(0,0,0, 1,8,32'hCAFE, LD_HU,1,RD, 0,0,0,  1,8,32'h00007F01, 0,0,0, 0,0, "lhu1");
      cyc(0,0,0, 1,8,32'hCAFE, ld_op_t'(3'd7),1,RD, 0,0,0,  1,8,32'h0000CAFE, 0,0,0, 0,0, "ldbad");
      // Stall holds, flush beats stall, next unstalled edge loads
      cyc(0,0,0, 1,7,32'hA5, LD_NONE,0,0, 0,0,0,  1,7,32'hA5, 0,0,0, 0,0, "ld7");
      cyc(0,1,0, 1,9,32'h77, LD_W,0,RD, 1,1,2,  1,7,32'hA5, 0,0,0, 0,0, "stall1");
      cyc(0,1,0, 1,10,32'h78, LD_B,1,RD, 1,1,2,  1,7,32'hA5, 0,0,0, 0,0, "stall2");
      cyc(0,1,0, 1,11,32'h79, LD_NONE,0,0, 1,1,2,  1,7,32'hA5, 0,0,0, 0,0, "stall3");
      cyc(0,1,1, 1,11,32'h79, LD_NONE,0,0, 1,1,2,  0,0,0, 0,0,0, 0,0, "flush");
      cyc(0,0,0, 1,9,32'h77, LD_NONE,0,0, 0,0,0,  1,9,32'h77, 0,0,0, 0,0, "resume");
      // HI/LO: registered request, commit one edge later, then reset clears
      cyc(0,0,0, 0,3,32'h1, LD_NONE,0,0, 1,HV,LV,  0,3,32'h1, 1,HV,LV, 0,0, "whilo");
      cyc(0,0,0, 0,0,0, LD_NONE,0,0, 0,0,0,  0,0,0, 0,0,0, HV,LV, "hilo");
      cyc(0,0,0, 0,0,0, LD_NONE,0,0, 1,32'h3,32'h4,  0,0,0, 1,32'h3,32'h4, HV,LV, "whilo2");
      cyc(1,0,0, 1,6,32'h9, LD_NONE,0,0, 1,32'h5,32'h6,  0,0,0, 0,0,0, 0,0, "rsthilo");
      cyc(0,0,0, 0,0,0, LD_NONE,0,0, 0,0,0,  0,0,0, 0,0,0, 0,0, "postrst");

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
